// File: rtl/rr_priority_arbiter_pkg.sv
// Purpose: shared types, sizes and helpers for the 8-requester arbiter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Expand a binary requester index into its one-hot grant vector.
  function automatic logic [N_REQ-1:0] onehot_from_idx(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Purpose: request/grant bundle between requesters and the arbiter.
// Latency: none (wiring only).
// Backpressure: the grant itself is the flow control; requesters wait for it.
interface rr_priority_arbiter_if
  import arb_pkg::*;
  ();

  logic [N_REQ-1:0] req;
  logic             release_i;
  logic             mode;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout_pulse;

  // Requester side drives requests and observes the grant.
  modport master (
    output req, release_i, mode,
    input  grant, grant_idx, grant_valid, timeout_pulse
  );

  // Arbiter side observes requests and drives the grant.
  modport slave (
    input  req, release_i, mode,
    output grant, grant_idx, grant_valid, timeout_pulse
  );

endinterface

// File: rtl/rr_priority_arbiter_pick.sv
// Purpose: combinational masked picker, fixed (highest index) or round-robin from start.
// Latency: combinational.
// Backpressure: none; found=0 when no unmasked request exists.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] start,
  input  logic             mode,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N_REQ-1:0] eff;
  logic [IDX_W-1:0] pos;

  assign eff = req & ~mask;

  // Later loop iterations overwrite earlier ones, so the loop order sets priority:
  // ascending for fixed (highest index wins), descending offset for round-robin
  // (smallest distance from start wins).
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    if (!mode) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (eff[i]) begin
          idx   = IDX_W'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        pos = start + IDX_W'(k);
        if (eff[pos]) begin
          idx   = pos;
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Purpose: 8-way arbiter holding a registered one-hot grant until release, drop or hold limit.
// Latency: one cycle from request to grant; back-to-back handover with no idle bubble.
// Backpressure: requesters hold req until granted; a timed-out sole owner sees one idle cycle.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_priority_arbiter_if.slave bus
);

  state_t           state, nxt_state;
  logic [N_REQ-1:0] grant_q, nxt_grant;
  logic [IDX_W-1:0] idx_q, nxt_idx;
  logic [IDX_W-1:0] rr_ptr, nxt_ptr;
  logic [CNT_W-1:0] hold_cnt, nxt_hold;
  logic             tmo_q, nxt_tmo;
  logic             valid_q;

  logic [N_REQ-1:0] pick_mask;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             owner_req;
  logic             at_limit;
  logic             do_grant;
  logic             go_idle;
  logic [IDX_W-1:0] win;

  // The current owner is excluded from re-arbitration so others get a turn.
  assign pick_mask = (state == BUSY) ? onehot_from_idx(idx_q) : '0;
  assign owner_req = bus.req[idx_q];
  assign at_limit  = (hold_cnt == CNT_W'(MAX_HOLD - 1));

  rr_pick u_pick (
    .req   (bus.req),
    .mask  (pick_mask),
    .start (rr_ptr),
    .mode  (bus.mode),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state logic: release and dropped request take precedence over the hold limit.
  always_comb begin
    nxt_state = state;
    nxt_grant = grant_q;
    nxt_idx   = idx_q;
    nxt_hold  = hold_cnt;
    nxt_ptr   = rr_ptr;
    nxt_tmo   = 1'b0;
    do_grant  = 1'b0;
    go_idle   = 1'b0;
    win       = pick_idx;
    case (state)
      IDLE: begin
        if (pick_found) do_grant = 1'b1;
      end
      BUSY: begin
        if (bus.release_i || !owner_req) begin
          if (pick_found) begin
            do_grant = 1'b1;
          end else if (owner_req) begin
            do_grant = 1'b1;
            win      = idx_q;
          end else begin
            go_idle = 1'b1;
          end
        end else if (at_limit) begin
          nxt_tmo = 1'b1;
          if (pick_found) do_grant = 1'b1;
          else            go_idle  = 1'b1;
        end else begin
          nxt_hold = hold_cnt + CNT_W'(1);
        end
      end
      default: go_idle = 1'b1;
    endcase
    if (do_grant) begin
      nxt_state = BUSY;
      nxt_grant = onehot_from_idx(win);
      nxt_idx   = win;
      nxt_hold  = '0;
      nxt_ptr   = win + IDX_W'(1);
    end else if (go_idle) begin
      nxt_state = IDLE;
      nxt_grant = '0;
      nxt_hold  = '0;
    end
  end

  // State and output registers; grant_idx is kept while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      tmo_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state    <= nxt_state;
      grant_q  <= nxt_grant;
      idx_q    <= nxt_idx;
      rr_ptr   <= nxt_ptr;
      hold_cnt <= nxt_hold;
      tmo_q    <= nxt_tmo;
      valid_q  <= |nxt_grant;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_idx     = idx_q;
  assign bus.grant_valid   = valid_q;
  assign bus.timeout_pulse = tmo_q;

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Sequential 8-requester arbiter that shares one downstream resource.
- Selects a winner with an 8:3 priority-encode function, then registers and holds a one-hot grant until the owner releases it, drops its request, or exceeds a hold limit.
- Two policies: fixed priority (highest index wins) or round-robin.
- Sits between request sources and the shared datapath; grant_idx drives the resource's select mux.

Parameters:
- N_REQ, 8, number of requesters; fixed at 8 in this revision.
- IDX_W, 3, width of grant_idx, equal to log2(N_REQ).
- MAX_HOLD, 16, maximum consecutive cycles one owner keeps the grant; legal range 2..31.
- CNT_W, 5, hold counter width; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request lines; bit k belongs to requester k.
- release_i  input  1  owner done; sampled only while grant_valid=1.
- mode  input  1  0 = fixed priority (req[7] highest), 1 = round-robin.
- grant  output  8  one-hot grant; all zero when idle.
- grant_idx  output  3  binary index of grant; holds last value when idle.
- grant_valid  output  1  high while any grant bit is set.
- timeout_pulse  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - grant=0, grant_idx=0, grant_valid=0, timeout_pulse=0.
  - state=IDLE, rr_ptr=0, hold_cnt=0.
- States: IDLE, BUSY. All outputs are registered.
- Winner selection (combinational):
  - mode=0: highest set bit of the request vector.
  - mode=1: first set bit searching upward from rr_ptr, wrapping 7->0.
  - mode is sampled only at decision points; a change mid-grant does not disturb the current owner.
- IDLE:
  - req!=0: on the next edge go to BUSY, assert the winner's grant bit, grant_idx and grant_valid, and set hold_cnt=0. Latency is one cycle from req to grant.
  - req==0: stay in IDLE.
- BUSY, end-of-tenure conditions (evaluated each cycle):
  - release_i=1, or req[grant_idx]=0, or hold_cnt==MAX_HOLD-1.
  - None true: increment hold_cnt and hold the grant.
- End of tenure by release_i=1 or dropped request:
  - Re-arbitrate in the same cycle over req with the owner's bit masked; the next owner is granted on the following edge with no idle bubble.
  - Masked vector empty but owner still requesting: re-grant the owner.
  - Nothing requesting: go to IDLE and clear grant.
- End of tenure by hold limit:
  - Revoke the grant and pulse timeout_pulse for 1 cycle.
  - Re-arbitrate with the owner's bit masked; if nothing else is requesting, go to IDLE for one cycle before the owner can re-win.
- rr_ptr update: at every new grant to index k, rr_ptr <= (k+1) mod 8, in both modes.
- Precedence: release_i and hold limit in the same cycle are treated as a release (no timeout_pulse).
- grant is always one-hot or zero; grant_valid == |grant.
- rst_n asserted mid-grant drops grant immediately (asynchronous), with no timeout_pulse.

Decomposition:
- Package arb_pkg:
  - State enum {IDLE, BUSY}.
  - Constants N_REQ=8, IDX_W=3.
  - Helper function onehot_from_idx.
- Sub-module rr_pick:
  - Combinational masked priority picker.
  - Inputs: req[7:0], mask[7:0], start[2:0], mode.
  - Outputs: idx[2:0], found.
  - Instantiated once; the top level holds the FSM, hold counter and rr_ptr.

Test Plan:
- Reset/idle: rst_n=0 then 1, req=8'h00 for 10 cycles -> grant=0, grant_valid=0, grant_idx=0, timeout_pulse=0 throughout.
- Fixed priority: mode=0, req=8'b1010_0101 -> one cycle later grant=8'h80, grant_idx=7. Then release_i=1 for 1 cycle with req=8'b0010_0101 -> next cycle grant=8'h20, with no idle cycle between grants.
- Round-robin rotation: mode=1, req=8'hFF held, release_i pulsed every 3 cycles -> grant_idx sequence 0,1,2,...,7,0 with no repeats.
- Hold limit: mode=1, req=8'h09, no release -> owner idx 0 held exactly 16 cycles. Then timeout_pulse=1 for 1 cycle and grant_idx=3 on the next cycle.
- Sole-requester timeout: req=8'h10 held, no release -> grant 16 cycles, timeout_pulse, 1 cycle grant=0, then grant=8'h10 again.
- Async reset mid-grant: grant=8'h04 active, rst_n low between clock edges -> grant=0 and grant_valid=0 immediately. After release of reset with req=8'h04 -> grant returns after 1 cycle and rr_ptr restarts at 0.
